// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// Optional build macro: BOOTH_EARLY_TERM_EN (see booth_mul_seq).
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/booth_mul_seq_addsub.sv
// Ripple add/subtract stage used by the Booth accumulator.
// op=1 subtracts b from a via two's complement; cout is the raw carry.
module booth_addsub #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] b_eff;

  assign b_eff = op ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, op};

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed WxW Booth multiplier, one step per clock.
// Define BOOTH_EARLY_TERM_EN to collapse trailing pure-shift steps.
module booth_mul_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product
);

  import booth_pkg::*;

  localparam int CW = cnt_w(W);

  state_e         state_q, state_d;
  logic [W:0]     a_q, a_d;
  logic [W:0]     m_q, m_d;
  logic [W-1:0]   q_q, q_d;
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] prod_q, prod_d;

  logic [1:0]     pair;
  logic           do_arith;
  logic [W:0]     sum;
  logic [W:0]     acc;
  logic           addsub_cout_unused;

  assign pair     = {q_q[0], qm1_q};
  assign do_arith = (pair == PAIR_ADD) || (pair == PAIR_SUB);

  booth_addsub #(
    .N(W + 1)
  ) u_addsub (
    .a    (a_q),
    .b    (m_q),
    .op   (pair == PAIR_SUB),
    .sum  (sum),
    .cout (addsub_cout_unused)
  );

  assign acc = do_arith ? sum : a_q;

`ifdef BOOTH_EARLY_TERM_EN
  logic                 all_eq;
  logic signed [2*W:0]  aq_sh;

  // Unconsumed multiplier bits all match q_m1: only shifts remain.
  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < W; i++) begin
      if ((i < int'(cnt_q)) && (q_q[i] != qm1_q)) begin
        all_eq = 1'b0;
      end
    end
  end

  assign aq_sh = $signed({a_q, q_q}) >>> cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = {mcand[W-1], mcand};
          a_d     = '0;
          q_d     = mplier;
          qm1_d   = 1'b0;
          cnt_d   = CW'(W);
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          prod_d  = {a_q[W-1:0], q_q};
          state_d = DONE;
`ifdef BOOTH_EARLY_TERM_EN
        end else if (all_eq) begin
          a_d   = aq_sh[2*W:W];
          q_d   = aq_sh[W-1:0];
          cnt_d = '0;
`endif
        end else begin
          a_d   = {acc[W], acc[W:1]};
          q_d   = {acc[0], q_q[W-1:1]};
          qm1_d = q_q[0];
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (W=16), both macro builds.
// Reference: plain signed multiply and a bit-scan latency model.
module tb_booth_mul_seq;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int n_tests;
  int n_fail;

  booth_mul_seq #(
    .W(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .mplier    (mplier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] a,
                                          input logic [15:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  // Edges from accept to out_valid.
  function automatic int ref_lat(input logic [15:0] b);
`ifdef BOOTH_EARLY_TERM_EN
    logic prev;
    bit   ok;
    for (int i = 0; i < W; i++) begin
      prev = 1'b0;
      if (i > 0) prev = b[i-1];
      ok = 1'b1;
      for (int j = i; j < W; j++)
        if (b[j] != prev) ok = 1'b0;
      if (ok) return i + 2;
    end
    return W + 1;
`else
    return W + 1;
`endif
  endfunction

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] p, output int lat);
    @(negedge clk);
    mcand    = a;
    mplier   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = product;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mcand     = '0;
    mplier    = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b product=%h want 1 0 0",
               in_ready, out_valid, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [15:0] ta [7];
    logic [15:0] tb [7];
    logic [31:0] tp [7];
    logic [31:0] p;
    int          lat;
    ta = '{16'd3, 16'd1034, 16'hFFF9, 16'h8000, 16'h8000, 16'h1234, 16'h7FFF};
    tb = '{16'd5, 16'd526,  16'd6,    16'h8000, 16'd1,    16'd0,    16'h7FFF};
    tp = '{32'h0000_000F, 32'h0008_4C8C, 32'hFFFF_FFD6, 32'h4000_0000,
           32'hFFFF_8000, 32'h0000_0000, 32'h3FFF_0001};
    for (int i = 0; i < 7; i++) begin
      do_op(ta[i], tb[i], p, lat);
      n_tests++;
      if (p !== tp[i]) begin
        n_fail++;
        $display("FAIL directed_prod[%0d]: got %h want %h", i, p, tp[i]);
      end
      n_tests++;
      if (lat != ref_lat(tb[i])) begin
        n_fail++;
        $display("FAIL directed_lat[%0d]: got %0d want %0d",
                 i, lat, ref_lat(tb[i]));
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] p0;
    int          lat;
    int          bad;
    out_ready = 1'b0;
    @(negedge clk);
    mcand    = 16'd7;
    mplier   = 16'hFFF7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    mcand  = 16'd100;
    mplier = 16'hFFFD;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p0 = product;
    n_tests++;
    if (p0 !== ref_mul(16'd7, 16'hFFF7)) begin
      n_fail++;
      $display("FAIL stall_prod: got %h want %h", p0,
               ref_mul(16'd7, 16'hFFF7));
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || product !== p0 || in_ready !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d unstable cycles want 0", bad);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_accept: in_ready=%b want 0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_tests++;
    if (product !== ref_mul(16'd100, 16'hFFFD) || lat != ref_lat(16'hFFFD)) begin
      n_fail++;
      $display("FAIL stall_next: got %h lat %0d want %h lat %0d", product,
               lat, ref_mul(16'd100, 16'hFFFD), ref_lat(16'hFFFD));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort;
    logic [31:0] p;
    int          lat;
    int          bad;
    out_ready = 1'b0;
    @(negedge clk);
    mcand    = 16'd12345;
    mplier   = 16'hFFFE;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_reset: in_ready=%b out_valid=%b product=%h want 1 0 0",
               in_ready, out_valid, product);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_stale: %0d bad cycles want 0", bad);
    end
    do_op(16'd2, 16'd2, p, lat);
    n_tests++;
    if (p !== 32'd4 || lat != ref_lat(16'd2)) begin
      n_fail++;
      $display("FAIL abort_after: got %h lat %0d want 00000004 lat %0d",
               p, lat, ref_lat(16'd2));
    end
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    int          lat;
    for (int i = 0; i < 80; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 4 == 1) b = 16'($urandom_range(0, 63));
      if (i % 4 == 2) b = 16'hFFFF ^ 16'($urandom_range(0, 63));
      if (i % 8 == 3) a = 16'h8000;
      do_op(a, b, p, lat);
      n_tests++;
      if (p !== ref_mul(a, b) || lat != ref_lat(b)) begin
        n_fail++;
        $display("FAIL random[%0d] %h*%h: got %h lat %0d want %h lat %0d",
                 i, a, b, p, lat, ref_mul(a, b), ref_lat(b));
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_stall();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
